// File: rtl/hs_elastic_fifo.sv
// Elastic req/ack FIFO between the graph `out` operator and its consumer.
// Optional stall/starve counters are enabled by defining HS_ELASTIC_FIFO_STATS_EN.
module hs_elastic_fifo #(
  parameter  int data_width = 32,
  parameter  int depth      = 8,
  localparam int cnt_width  = $clog2(depth) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  up_req,
  input  logic                  up_ack,
  input  logic [data_width-1:0] up_din,
  input  logic                  dn_req,
  output logic                  dn_ack,
  output logic [data_width-1:0] dn_dout,
  output logic [cnt_width-1:0]  count,
  output logic                  empty,
  output logic                  full,
`ifdef HS_ELASTIC_FIFO_STATS_EN
  output logic [31:0]           stall_up,
  output logic [31:0]           starve_dn,
`endif
  output logic                  overflow
);

  localparam int aw = $clog2(depth);

  logic [data_width-1:0] mem_q [depth];
  logic [data_width-1:0] mem_d [depth];
  logic [aw-1:0]         wr_ptr_q, wr_ptr_d;
  logic [aw-1:0]         rd_ptr_q, rd_ptr_d;
  logic [cnt_width-1:0]  count_q, count_d;
  logic                  up_req_q, up_req_d;
  logic                  dn_ack_q, dn_ack_d;
  logic [data_width-1:0] dn_dout_q, dn_dout_d;
  logic                  overflow_q, overflow_d;
  logic                  is_full, is_empty, push, pop;

  assign is_full  = (count_q == cnt_width'(depth));
  assign is_empty = (count_q == '0);

  // Pop decision uses the pre-push count, so a word never bypasses storage.
  assign pop  = dn_req & ~dn_ack_q & ~is_empty;
  // A coincident pop frees the slot, so an ack at full is accepted then.
  assign push = up_ack & (~is_full | pop);

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = up_din;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dn_ack_d   = 1'b0;
    dn_dout_d  = dn_dout_q;
    overflow_d = overflow_q | (up_ack & ~push);
    if (push) wr_ptr_d = wr_ptr_q + aw'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + aw'(1);
      dn_ack_d  = 1'b1;
      dn_dout_d = mem_q[rd_ptr_q];
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_width'(1);
      2'b01:   count_d = count_q - cnt_width'(1);
      default: count_d = count_q;
    endcase
    // Two-slot margin covers the one ack upstream may still emit after req drops.
    up_req_d = (count_d <= cnt_width'(depth - 2));
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      up_req_q   <= 1'b0;
      dn_ack_q   <= 1'b0;
      dn_dout_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      up_req_q   <= up_req_d;
      dn_ack_q   <= dn_ack_d;
      dn_dout_q  <= dn_dout_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef HS_ELASTIC_FIFO_STATS_EN
  logic [31:0] stall_up_q, stall_up_d;
  logic [31:0] starve_dn_q, starve_dn_d;

  always_comb begin
    stall_up_d  = stall_up_q;
    starve_dn_d = starve_dn_q;
    if (~up_req_q && stall_up_q != '1) stall_up_d = stall_up_q + 32'd1;
    if (dn_req && is_empty && ~dn_ack_q && starve_dn_q != '1)
      starve_dn_d = starve_dn_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_up_q  <= '0;
      starve_dn_q <= '0;
    end else begin
      stall_up_q  <= stall_up_d;
      starve_dn_q <= starve_dn_d;
    end
  end

  assign stall_up  = stall_up_q;
  assign starve_dn = starve_dn_q;
`endif

  assign up_req   = up_req_q;
  assign dn_ack   = dn_ack_q;
  assign dn_dout  = dn_dout_q;
  assign count    = count_q;
  assign empty    = is_empty;
  assign full     = is_full;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_hs_elastic_fifo.sv
// Directed bench for hs_elastic_fifo (default build, depth 8).
module tb_hs_elastic_fifo;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          up_ack = 1'b0;
  logic          dn_req = 1'b0;
  logic [DW-1:0] up_din = '0;
  logic          up_req, dn_ack, empty, full, overflow;
  logic [DW-1:0] dn_dout;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  hs_elastic_fifo #(.data_width(DW), .depth(8)) dut (
    .clk(clk), .rst(rst),
    .up_req(up_req), .up_ack(up_ack), .up_din(up_din),
    .dn_req(dn_req), .dn_ack(dn_ack), .dn_dout(dn_dout),
    .count(count), .empty(empty), .full(full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input logic [DW-1:0] exp[$], input string tag);
    int got = 0;
    up_ack = 1'b0;
    dn_req = 1'b1;
    for (int c = 0; c < 64 && got < exp.size(); c++) begin
      tick();
      if (dn_ack) begin
        check($sformatf("%s[%0d]", tag, got), dn_dout, exp[got]);
        got++;
      end
    end
    dn_req = 1'b0;
    check({tag, "_words"}, DW'(got), DW'(exp.size()));
    tick();
  endtask

  task automatic stream(input int fail);
    int  sent = 0;
    int  rcvd = 0;
    bit  ack_prev = 1'b0;
    for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
      up_ack = 1'b0;
      if (up_req && !ack_prev && sent < 1000 && $urandom_range(99) >= fail) begin
        up_ack = 1'b1;
        up_din = DW'(sent);
        sent++;
      end
      ack_prev = up_ack;
      dn_req = ($urandom_range(99) >= fail);
      tick();
      if (dn_ack) begin
        if (dn_dout !== DW'(rcvd))
          check($sformatf("stream%0d[%0d]", fail, rcvd), dn_dout, DW'(rcvd));
        rcvd++;
      end
    end
    up_ack = 1'b0;
    dn_req = 1'b0;
    check($sformatf("stream%0d_rcvd", fail), DW'(rcvd), 32'd1000);
    check($sformatf("stream%0d_ovf", fail), DW'(overflow), 32'd0);
    tick();
    tick();
    check($sformatf("stream%0d_cnt", fail), DW'(count), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] q[$];

    // Reset state
    tick();
    tick();
    check("rst_up_req", DW'(up_req), 0);
    check("rst_dn_ack", DW'(dn_ack), 0);
    check("rst_count", DW'(count), 0);
    check("rst_empty", DW'(empty), 1);
    check("rst_full", DW'(full), 0);
    check("rst_ovf", DW'(overflow), 0);
    check("rst_dout", dn_dout, 0);
    rst = 1'b0;
    #1;
    check("rel1_up_req", DW'(up_req), 0);
    tick();
    check("rel2_up_req", DW'(up_req), 1);

    // Single word with consumer already requesting
    up_ack = 1'b1; up_din = 32'h5; dn_req = 1'b1;
    tick();
    up_ack = 1'b0;
    check("single_cnt1", DW'(count), 1);
    check("single_noack", DW'(dn_ack), 0);
    tick();
    check("single_ack", DW'(dn_ack), 1);
    check("single_data", dn_dout, 32'h5);
    check("single_cnt0", DW'(count), 0);
    tick();
    check("single_ack_once", DW'(dn_ack), 0);
    check("single_hold", dn_dout, 32'h5);
    dn_req = 1'b0;
    tick();

    // Fill toward full; up_req drops at count 7
    for (int i = 0; i < 7; i++) begin
      up_ack = 1'b1; up_din = DW'(i);
      tick();
      if (i == 5) check("fill6_up_req", DW'(up_req), 1);
      if (i == 6) check("fill7_up_req", DW'(up_req), 0);
    end
    check("fill7_cnt", DW'(count), 7);
    up_din = 32'h7;
    tick();
    up_ack = 1'b0;
    check("fill8_cnt", DW'(count), 8);
    check("fill8_full", DW'(full), 1);
    check("fill8_ovf", DW'(overflow), 0);

    // Push coincident with pop at full
    up_ack = 1'b1; up_din = 32'hAB; dn_req = 1'b1;
    tick();
    up_ack = 1'b0; dn_req = 1'b0;
    check("conc_cnt", DW'(count), 8);
    check("conc_ovf", DW'(overflow), 0);
    check("conc_ack", DW'(dn_ack), 1);
    check("conc_data", dn_dout, 32'h0);

    // Forced ack at full is discarded
    up_ack = 1'b1; up_din = 32'h99;
    tick();
    up_ack = 1'b0;
    check("ovf_set", DW'(overflow), 1);
    check("ovf_cnt", DW'(count), 8);
    tick();
    check("ovf_sticky", DW'(overflow), 1);

    q = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'hAB};
    drain(q, "drain");
    check("drain_cnt", DW'(count), 0);
    check("drain_empty", DW'(empty), 1);
    check("drain_ovf", DW'(overflow), 1);

    // Streaming with compliant producer/consumer
    rst = 1'b1; tick(); rst = 1'b0; tick();
    stream(0);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    stream(30);

    // Reset mid-stream
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      up_ack = 1'b1; up_din = DW'(32'h10 + i);
      tick();
    end
    up_ack = 1'b0;
    check("mid_cnt4", DW'(count), 4);
    rst = 1'b1; dn_req = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_cnt0", DW'(count), 0);
    check("mid_ack0", DW'(dn_ack), 0);
    check("mid_up_req", DW'(up_req), 0);
    check("mid_dout", dn_dout, 0);
    tick();
    check("mid_ack1", DW'(dn_ack), 0);
    tick();
    check("mid_ack2", DW'(dn_ack), 0);
    up_ack = 1'b1; up_din = 32'hA;
    tick();
    up_ack = 1'b0;
    check("mid_push_cnt", DW'(count), 1);
    tick();
    check("mid_first_ack", DW'(dn_ack), 1);
    check("mid_first_data", dn_dout, 32'hA);
    dn_req = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
